life_tracker: RTL and testbench



---
 rtl/life_pkg.sv | 42 ++++
 rtl/life_tracker_if.sv | 23 ++
 rtl/frame_edge.sv | 24 ++
 rtl/life_tracker.sv | 124 ++++++++++++
 tb/tb_life_tracker.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/life_pkg.sv
// Shared types and defaults for the player-lives tracker: spare-life encoding,
// FSM states, default frame counts and small helpers.
package life_pkg;

    typedef enum logic [1:0] {
        LIFE_TWO  = 2'b00,
        LIFE_ONE  = 2'b01,
        LIFE_NONE = 2'b10,
        LIFE_IDLE = 2'b11
    } life_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIVE,
        ST_DYING,
        ST_RESPAWN,
        ST_GAME_OVER
    } tracker_state_e;

    localparam int DEATH_FRAMES_DEF  = 60;
    localparam int INVULN_FRAMES_DEF = 120;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic life_state_e life_dec(input life_state_e l);
        case (l)
            LIFE_TWO: return LIFE_ONE;
            default:  return LIFE_NONE;
        endcase
    endfunction

    // Awarding a life saturates at two spare.
    function automatic life_state_e life_inc(input life_state_e l);
        case (l)
            LIFE_NONE: return LIFE_ONE;
            default:   return LIFE_TWO;
        endcase
    endfunction

endpackage

// File: rtl/life_tracker_if.sv
// Signal bundle between game control / collision logic (master) and the
// life tracker (slave); life_state feeds the lives-icon decoder.
interface life_tracker_if;
    logic       frame_clk;
    logic       game_start;
    logic       player_hit;
    logic       extra_life;
    logic [1:0] life_state;
    logic       dying;
    logic       invuln;
    logic       respawn;
    logic       game_over;

    modport master (
        output frame_clk, game_start, player_hit, extra_life,
        input  life_state, dying, invuln, respawn, game_over
    );

    modport slave (
        input  frame_clk, game_start, player_hit, extra_life,
        output life_state, dying, invuln, respawn, game_over
    );
endinterface

// File: rtl/frame_edge.sv
// Registered rising-edge detector: turns the vsync-derived frame_clk level
// into a one-Clk-cycle frame_tick, one cycle after the edge.
module frame_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic frame_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_d    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_d    <= frame_clk;
            frame_tick <= frame_clk & ~frame_d;
        end
    end

endmodule

// File: rtl/life_tracker.sv
// Spare-life tracker: death animation, respawn invulnerability, game-over.
// Optional macro EXTRA_LIFE_EN enables extra_life awards; otherwise it is ignored.
module life_tracker
    import life_pkg::*;
#(
    parameter int DEATH_FRAMES  = DEATH_FRAMES_DEF,
    parameter int INVULN_FRAMES = INVULN_FRAMES_DEF
) (
    input logic           Clk,
    input logic           Reset,
    life_tracker_if.slave bus
);

    localparam int CNT_W = $clog2(max_int(DEATH_FRAMES, INVULN_FRAMES) + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t DEATH_LAST  = cnt_t'(DEATH_FRAMES - 1);
    localparam cnt_t INVULN_LAST = cnt_t'(INVULN_FRAMES - 1);

    tracker_state_e state, state_next;
    life_state_e    life, life_next, life_award;
    cnt_t           count, count_next;
    logic           respawn_q, respawn_next;
    logic           frame_tick;
    logic           award;

    frame_edge u_frame_edge (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (bus.frame_clk),
        .frame_tick (frame_tick)
    );

`ifdef EXTRA_LIFE_EN
    assign award = bus.extra_life;
`else
    logic unused_extra_life;
    assign unused_extra_life = bus.extra_life;
    assign award             = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            life      <= LIFE_IDLE;
            count     <= '0;
            respawn_q <= 1'b0;
        end else begin
            state     <= state_next;
            life      <= life_next;
            count     <= count_next;
            respawn_q <= respawn_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_next   = state;
        life_next    = life;
        count_next   = count;
        respawn_next = 1'b0;
        life_award   = award ? life_inc(life) : life;

        if (bus.game_start) begin
            state_next = ST_ALIVE;
            life_next  = LIFE_TWO;
            count_next = '0;
        end else begin
            case (state)
                ST_IDLE, ST_GAME_OVER: ;
                ST_ALIVE: begin
                    life_next = life_award;
                    if (bus.player_hit) begin
                        state_next = ST_DYING;
                        count_next = '0;
                    end
                end
                ST_DYING: begin
                    // An award on the final tick lands before the decrement.
                    life_next = life_award;
                    if (frame_tick) begin
                        if (count == DEATH_LAST) begin
                            count_next = '0;
                            if (life_award == LIFE_NONE) begin
                                state_next = ST_GAME_OVER;
                            end else begin
                                state_next   = ST_RESPAWN;
                                life_next    = life_dec(life_award);
                                respawn_next = 1'b1;
                            end
                        end else begin
                            count_next = count + 1'b1;
                        end
                    end
                end
                ST_RESPAWN: begin
                    life_next = life_award;
                    if (frame_tick) begin
                        if (count == INVULN_LAST) begin
                            state_next = ST_ALIVE;
                            count_next = '0;
                        end else begin
                            count_next = count + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    life_next  = LIFE_IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.life_state = life;
        bus.dying      = (state == ST_DYING);
        bus.invuln     = (state == ST_RESPAWN);
        bus.game_over  = (state == ST_GAME_OVER);
        bus.respawn    = respawn_q;
    end

endmodule

// File: tb/tb_life_tracker.sv
// Directed bench for life_tracker with DEATH_FRAMES=4, INVULN_FRAMES=3;
// the extra-life scenario runs only when EXTRA_LIFE_EN is defined.
module tb_life_tracker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   respawn_cnt = 0;

    life_tracker_if bus ();

    life_tracker #(
        .DEATH_FRAMES  (4),
        .INVULN_FRAMES (3)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.respawn === 1'b1) respawn_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input bit with_extra);
        bus.frame_clk = 1'b1;
        @(negedge clk);
        bus.frame_clk  = 1'b0;
        bus.extra_life = with_extra;
        @(negedge clk);
        bus.extra_life = 1'b0;
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        repeat (n) frame(1'b0);
    endtask

    task automatic start_game;
        bus.game_start = 1'b1;
        @(negedge clk);
        bus.game_start = 1'b0;
    endtask

    task automatic hit;
        bus.player_hit = 1'b1;
        @(negedge clk);
        bus.player_hit = 1'b0;
    endtask

    task automatic test_reset;
        bus.frame_clk = 1'b0; bus.game_start = 1'b0;
        bus.player_hit = 1'b0; bus.extra_life = 1'b0;
        rst = 1'b1;
        cyc(2);
        checks++; if (bus.life_state !== 2'b11) begin errors++; $display("FAIL reset_life: got %b expected 11", bus.life_state); end
        checks++; if ({bus.dying, bus.invuln, bus.respawn, bus.game_over} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.dying, bus.invuln, bus.respawn, bus.game_over}); end
        rst = 1'b0;
        cyc(1);
        hit();
        checks++; if (bus.dying !== 1'b0) begin errors++; $display("FAIL idle_hit_dying: got %b expected 0", bus.dying); end
        checks++; if (bus.life_state !== 2'b11) begin errors++; $display("FAIL idle_hit_life: got %b expected 11", bus.life_state); end
    endtask

    task automatic test_start;
        start_game();
        checks++; if (bus.life_state !== 2'b00) begin errors++; $display("FAIL start_life: got %b expected 00", bus.life_state); end
        checks++; if ({bus.dying, bus.game_over} !== 2'b00) begin errors++; $display("FAIL start_flags: got %b expected 00", {bus.dying, bus.game_over}); end
    endtask

    task automatic test_death_respawn;
        int snap;
        hit();
        checks++; if (bus.dying !== 1'b1) begin errors++; $display("FAIL hit_dying: got %b expected 1", bus.dying); end
        snap = respawn_cnt;
        for (int i = 1; i <= 3; i++) begin
            frame(1'b0);
            checks++; if (bus.dying !== 1'b1) begin errors++; $display("FAIL dying_frame%0d: got %b expected 1", i, bus.dying); end
        end
        frame(1'b0);
        checks++; if (bus.dying !== 1'b0) begin errors++; $display("FAIL dying_end: got %b expected 0", bus.dying); end
        checks++; if (bus.life_state !== 2'b01) begin errors++; $display("FAIL death1_life: got %b expected 01", bus.life_state); end
        checks++; if (bus.invuln !== 1'b1) begin errors++; $display("FAIL respawn_invuln: got %b expected 1", bus.invuln); end
        checks++; if (respawn_cnt - snap !== 1) begin errors++; $display("FAIL respawn_pulse_cycles: got %0d expected 1", respawn_cnt - snap); end
        frames(2);
        checks++; if (bus.invuln !== 1'b1) begin errors++; $display("FAIL invuln_hold: got %b expected 1", bus.invuln); end
        frame(1'b0);
        checks++; if (bus.invuln !== 1'b0) begin errors++; $display("FAIL invuln_end: got %b expected 0", bus.invuln); end
        hit();
        checks++; if (bus.dying !== 1'b1) begin errors++; $display("FAIL alive_again_hit: got %b expected 1", bus.dying); end
    endtask

    task automatic test_game_over;
        int snap;
        frames(4);
        checks++; if (bus.life_state !== 2'b10) begin errors++; $display("FAIL death2_life: got %b expected 10", bus.life_state); end
        frames(3);
        hit();
        snap = respawn_cnt;
        frames(4);
        checks++; if (bus.game_over !== 1'b1) begin errors++; $display("FAIL game_over: got %b expected 1", bus.game_over); end
        checks++; if (bus.life_state !== 2'b10) begin errors++; $display("FAIL game_over_life: got %b expected 10", bus.life_state); end
        checks++; if ({bus.dying, bus.invuln} !== 2'b00) begin errors++; $display("FAIL game_over_flags: got %b expected 00", {bus.dying, bus.invuln}); end
        checks++; if (respawn_cnt !== snap) begin errors++; $display("FAIL game_over_no_respawn: got %0d expected %0d", respawn_cnt, snap); end
        hit();
        checks++; if ({bus.game_over, bus.dying, bus.life_state} !== 4'b1010) begin errors++; $display("FAIL game_over_hit: got %b expected 1010", {bus.game_over, bus.dying, bus.life_state}); end
        start_game();
        checks++; if ({bus.game_over, bus.life_state} !== 3'b000) begin errors++; $display("FAIL restart_from_over: got %b expected 000", {bus.game_over, bus.life_state}); end
    endtask

    task automatic test_hit_in_respawn;
        hit();
        frames(4);
        hit();
        checks++; if (bus.dying !== 1'b0) begin errors++; $display("FAIL respawn_hit_dying: got %b expected 0", bus.dying); end
        checks++; if ({bus.invuln, bus.life_state} !== 3'b101) begin errors++; $display("FAIL respawn_hit_state: got %b expected 101", {bus.invuln, bus.life_state}); end
        frames(3);
        checks++; if ({bus.invuln, bus.dying} !== 2'b00) begin errors++; $display("FAIL respawn_hit_no_queue: got %b expected 00", {bus.invuln, bus.dying}); end
    endtask

    task automatic test_restart;
        int snap;
        snap = respawn_cnt;
        hit();
        frames(2);
        start_game();
        checks++; if ({bus.dying, bus.invuln, bus.life_state} !== 4'b0000) begin errors++; $display("FAIL restart_dying: got %b expected 0000", {bus.dying, bus.invuln, bus.life_state}); end
        checks++; if (respawn_cnt !== snap) begin errors++; $display("FAIL restart_no_respawn: got %0d expected %0d", respawn_cnt, snap); end
        hit();
        frames(3);
        checks++; if (bus.dying !== 1'b1) begin errors++; $display("FAIL restart_counter_cleared: got %b expected 1", bus.dying); end
        frame(1'b0);
        checks++; if ({bus.invuln, bus.life_state} !== 3'b101) begin errors++; $display("FAIL restart_then_death: got %b expected 101", {bus.invuln, bus.life_state}); end
        start_game();
        checks++; if ({bus.invuln, bus.life_state} !== 3'b000) begin errors++; $display("FAIL restart_in_respawn: got %b expected 000", {bus.invuln, bus.life_state}); end
    endtask

    task automatic test_reset_mid_dying;
        hit();
        frames(2);
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.life_state !== 2'b11) begin errors++; $display("FAIL async_reset_life: got %b expected 11", bus.life_state); end
        checks++; if ({bus.dying, bus.invuln, bus.respawn, bus.game_over} !== 4'b0000) begin errors++; $display("FAIL async_reset_flags: got %b expected 0000", {bus.dying, bus.invuln, bus.respawn, bus.game_over}); end
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        checks++; if (bus.life_state !== 2'b11) begin errors++; $display("FAIL post_reset_idle: got %b expected 11", bus.life_state); end
    endtask

`ifdef EXTRA_LIFE_EN
    task automatic pulse_extra;
        bus.extra_life = 1'b1;
        @(negedge clk);
        bus.extra_life = 1'b0;
    endtask

    task automatic test_extra_life;
        start_game();
        hit(); frames(4); frames(3);
        hit(); frames(4); frames(3);
        checks++; if (bus.life_state !== 2'b10) begin errors++; $display("FAIL extra_setup: got %b expected 10", bus.life_state); end
        pulse_extra();
        checks++; if (bus.life_state !== 2'b01) begin errors++; $display("FAIL extra_10_to_01: got %b expected 01", bus.life_state); end
        pulse_extra();
        pulse_extra();
        checks++; if (bus.life_state !== 2'b00) begin errors++; $display("FAIL extra_saturate: got %b expected 00", bus.life_state); end
        hit(); frames(4); frames(3);
        hit(); frames(4); frames(3);
        hit(); frames(3);
        frame(1'b1);
        checks++; if (bus.life_state !== 2'b10) begin errors++; $display("FAIL extra_final_tick_life: got %b expected 10", bus.life_state); end
        checks++; if ({bus.game_over, bus.invuln, bus.dying} !== 3'b010) begin errors++; $display("FAIL extra_final_tick_state: got %b expected 010", {bus.game_over, bus.invuln, bus.dying}); end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_death_respawn();
        test_game_over();
        test_hit_in_respawn();
        test_restart();
        test_reset_mid_dying();
`ifdef EXTRA_LIFE_EN
        test_extra_life();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
